// File: rtl/flow_ram_updater_if.sv
// Signal bundle between the flow updater, the flow lookup stage and sram_reset_intf.
// master = updater side; slave = upstream lookup stage plus the RAM interface.
`ifndef FLOW_RAM_ADDR_WIDTH
`define FLOW_RAM_ADDR_WIDTH 10
`endif
`ifndef FLOW_RAM_WORD_WIDTH
`define FLOW_RAM_WORD_WIDTH 64
`endif

interface flow_ram_updater_if #(
  parameter int ADDR_WIDTH  = `FLOW_RAM_ADDR_WIDTH,
  parameter int WORD_WIDTH  = `FLOW_RAM_WORD_WIDTH,
  parameter int BYTES_WIDTH = 16
);
  logic                   upd_valid;
  logic                   upd_ready;
  logic [ADDR_WIDTH-1:0]  upd_addr;
  logic [BYTES_WIDTH-1:0] upd_bytes;
  logic                   upd_done;

  logic                   write_ready;
  logic                   write_en;
  logic [ADDR_WIDTH-1:0]  write_addr;
  logic [WORD_WIDTH-1:0]  write_data;

  logic                   read_ready;
  logic                   read_en;
  logic [ADDR_WIDTH-1:0]  read_addr;
  logic [WORD_WIDTH-1:0]  read_data;
  logic                   read_data_new;

  modport master (
    input  upd_valid, upd_addr, upd_bytes,
    output upd_ready, upd_done,
    input  write_ready,
    output write_en, write_addr, write_data,
    input  read_ready, read_data, read_data_new,
    output read_en, read_addr
  );

  modport slave (
    output upd_valid, upd_addr, upd_bytes,
    input  upd_ready, upd_done,
    output write_ready,
    input  write_en, write_addr, write_data,
    output read_ready, read_data, read_data_new,
    input  read_en, read_addr
  );
endinterface

// File: rtl/flow_ram_updater.sv
// Read-modify-write flow counter updater: reads a flow word, bumps the packet and
// byte counters with saturation, writes it back. One update in flight at a time.
`ifndef FLOW_RAM_ADDR_WIDTH
`define FLOW_RAM_ADDR_WIDTH 10
`endif
`ifndef FLOW_RAM_WORD_WIDTH
`define FLOW_RAM_WORD_WIDTH 64
`endif

module flow_ram_updater #(
  parameter int ADDR_WIDTH  = `FLOW_RAM_ADDR_WIDTH,
  parameter int WORD_WIDTH  = `FLOW_RAM_WORD_WIDTH,
  parameter int PKT_WIDTH   = 24,
  parameter int BYTES_WIDTH = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                reset,
  flow_ram_updater_if.master  bus,
  output logic                err_timeout
);

  localparam int FIELD_W = WORD_WIDTH - PKT_WIDTH;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_REQ    = 2'd1,
    WAIT_DATA = 2'd2,
    WR_REQ    = 2'd3
  } state_t;

  function automatic logic [PKT_WIDTH-1:0] sat_pkt_inc(input logic [PKT_WIDTH-1:0] pkt);
    return (&pkt) ? pkt : pkt + PKT_WIDTH'(1);
  endfunction

  // upd_bytes is zero-extended; the extra sum bit flags overflow of the byte field.
  function automatic logic [FIELD_W-1:0] sat_byte_add(input logic [FIELD_W-1:0]     acc,
                                                      input logic [BYTES_WIDTH-1:0] inc);
    logic [FIELD_W:0] sum;
    sum = {1'b0, acc} + (FIELD_W + 1)'(inc);
    return sum[FIELD_W] ? {FIELD_W{1'b1}} : sum[FIELD_W-1:0];
  endfunction

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [BYTES_WIDTH-1:0] req_bytes;
  logic [7:0]             tmo_cnt;
  logic                   upd_ready_r;
  logic                   upd_done_r;
  logic                   read_en_r;
  logic                   write_en_r;
  logic [ADDR_WIDTH-1:0]  read_addr_r;
  logic [ADDR_WIDTH-1:0]  write_addr_r;
  logic [WORD_WIDTH-1:0]  wr_word_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      req_addr     <= '0;
      req_bytes    <= '0;
      tmo_cnt      <= '0;
      upd_ready_r  <= 1'b0;
      upd_done_r   <= 1'b0;
      read_en_r    <= 1'b0;
      write_en_r   <= 1'b0;
      read_addr_r  <= '0;
      write_addr_r <= '0;
      wr_word_p1   <= '0;
      err_timeout  <= 1'b0;
    end else begin
      read_en_r  <= 1'b0;
      write_en_r <= 1'b0;
      upd_done_r <= 1'b0;
      case (state)
        // upd_ready rises one cycle after re-entering IDLE, never in the write-back cycle
        IDLE: begin
          if (bus.upd_valid && upd_ready_r) begin
            req_addr    <= bus.upd_addr;
            req_bytes   <= bus.upd_bytes;
            upd_ready_r <= 1'b0;
            state       <= RD_REQ;
          end else begin
            upd_ready_r <= 1'b1;
          end
        end
        // read_ready low means the RAM is still clearing; no timeout applies here
        RD_REQ: begin
          if (bus.read_ready) begin
            read_en_r   <= 1'b1;
            read_addr_r <= req_addr;
            tmo_cnt     <= '0;
            state       <= WAIT_DATA;
          end
        end
        // Stage p1: read data arrives, updated word registered for write-back
        WAIT_DATA: begin
          if (bus.read_data_new) begin
            wr_word_p1 <= {sat_byte_add(bus.read_data[WORD_WIDTH-1:PKT_WIDTH], req_bytes),
                           sat_pkt_inc(bus.read_data[PKT_WIDTH-1:0])};
            state      <= WR_REQ;
          end else if (tmo_cnt == TMO_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WR_REQ: begin
          if (bus.write_ready) begin
            write_en_r   <= 1'b1;
            upd_done_r   <= 1'b1;
            write_addr_r <= req_addr;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.upd_ready  = upd_ready_r;
  assign bus.upd_done   = upd_done_r;
  assign bus.read_en    = read_en_r;
  assign bus.read_addr  = read_addr_r;
  assign bus.write_en   = write_en_r;
  assign bus.write_addr = write_addr_r;
  assign bus.write_data = wr_word_p1;

endmodule

// File: tb/tb_flow_ram_updater.sv
// Bench for flow_ram_updater: RAM responder, scoreboard with a saturating-counter model,
// a table of directed updates, hand-written corner sequences and a randomized phase.
`timescale 1ns/1ps
module tb_flow_ram_updater;
  localparam int AW = 10;
  localparam int WW = 64;
  localparam int PW = 24;
  localparam int BW = 16;
  localparam int FW = WW - PW;
  localparam int NMEM = 1 << AW;
  localparam longint PMAX = 64'd16777215;
  localparam longint BMAX = 64'd1099511627775;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_timeout;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  flow_ram_updater_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BYTES_WIDTH(BW)) ifc ();

  flow_ram_updater #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .PKT_WIDTH(PW), .BYTES_WIDTH(BW), .TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .bus(ifc.master), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WW-1:0] model_word(input logic [WW-1:0] old, input logic [BW-1:0] b);
    longint pkt;
    longint byt;
    pkt = longint'(old[PW-1:0]) + 64'sd1;
    byt = longint'(old[WW-1:PW]) + longint'(b);
    if (pkt > PMAX) pkt = PMAX;
    if (byt > BMAX) byt = BMAX;
    return {byt[FW-1:0], pkt[PW-1:0]};
  endfunction

  // RAM responder: read data returns rd_lat cycles after read_en is seen
  logic [WW-1:0] mem [NMEM];
  logic [WW-1:0] ref_mem [NMEM];
  int            rd_lat = 2;
  bit            suppress = 1'b0;
  int            pend = 0;
  logic [AW-1:0] pend_addr = '0;
  logic          sram_rdn = 1'b0;
  logic          noise_rdn = 1'b0;
  logic [WW-1:0] sram_rdata = '0;

  assign ifc.read_data     = sram_rdata;
  assign ifc.read_data_new = sram_rdn | noise_rdn;

  always @(negedge clk) begin
    sram_rdn = 1'b0;
    if (ifc.read_en) begin
      pend = rd_lat;
      pend_addr = ifc.read_addr;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0 && !suppress) begin
        sram_rdn = 1'b1;
        sram_rdata = mem[pend_addr];
      end
    end
    if (ifc.write_en) mem[ifc.write_addr] = ifc.write_data;
  end

  // Monitor and scoreboard
  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] bytes;
  } req_t;
  req_t exp_q[$];
  int   ev_q[$];
  int   rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int   rd_cyc = 0, wr_cyc = 0, err_cyc = 0, rdy_cyc = 0;
  logic [AW-1:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [WW-1:0] last_wr_data = '0;
  logic rr_prev = 1'b0, wr_prev = 1'b0, ren_prev = 1'b0, wen_prev = 1'b0;
  logic err_prev = 1'b0, ur_prev = 1'b0;

  always @(negedge clk) begin
    req_t r;
    logic [WW-1:0] e;
    if (reset) begin
      if (ifc.upd_valid && ifc.upd_ready) exp_q.push_back('{ifc.upd_addr, ifc.upd_bytes});
      if (ifc.read_en) begin
        rd_cnt++;
        rd_cyc = cyc;
        last_rd_addr = ifc.read_addr;
        ev_q.push_back(int'(ifc.read_addr));
        chk("read_after_ready", 64'(rr_prev), 64'd1);
        chk("read_single_pulse", 64'(ren_prev), 64'd0);
        chk("read_has_request", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("read_addr", 64'(ifc.read_addr), 64'(exp_q[0].addr));
      end
      if (ifc.write_en) begin
        wr_cnt++;
        wr_cyc = cyc;
        last_wr_addr = ifc.write_addr;
        last_wr_data = ifc.write_data;
        ev_q.push_back(32'h10000 | int'(ifc.write_addr));
        chk("write_after_ready", 64'(wr_prev), 64'd1);
        chk("write_single_pulse", 64'(wen_prev), 64'd0);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          e = model_word(ref_mem[r.addr], r.bytes);
          ref_mem[r.addr] = e;
          chk("sb_write_addr", 64'(ifc.write_addr), 64'(r.addr));
          chk("sb_write_data", ifc.write_data, e);
        end else begin
          chk("write_has_request", 64'(exp_q.size()), 64'd1);
        end
      end
      if (ifc.upd_done || ifc.write_en) chk("done_with_write", 64'(ifc.upd_done), 64'(ifc.write_en));
      if (ifc.upd_done) done_cnt++;
      if (ifc.upd_ready && !ur_prev) rdy_cyc = cyc;
      if (err_timeout && !err_prev) begin
        err_cyc = cyc;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    rr_prev  = ifc.read_ready;
    wr_prev  = ifc.write_ready;
    ren_prev = ifc.read_en;
    wen_prev = ifc.write_en;
    err_prev = err_timeout;
    ur_prev  = ifc.upd_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic preload(input int a, input logic [WW-1:0] w);
    mem[a] = w;
    ref_mem[a] = w;
  endtask

  task automatic wait_accept(output int acc);
    logic rdy;
    int n;
    n = 0;
    do begin
      rdy = ifc.upd_ready;
      tick();
      n++;
    end while (!rdy && n < 2000);
    acc = cyc;
    if (!rdy) chk("accept", 64'(rdy), 64'd1);
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b, output int acc);
    ifc.upd_valid = 1'b1;
    ifc.upd_addr  = a;
    ifc.upd_bytes = b;
    wait_accept(acc);
    ifc.upd_valid = 1'b0;
  endtask

  task automatic wait_write(input int wr0, input int bound);
    int n;
    n = 0;
    while (wr_cnt == wr0 && n < bound) begin
      tick();
      n++;
    end
    if (wr_cnt == wr0) chk("write_wait", 64'(wr_cnt), 64'(wr0 + 1));
  endtask

  task automatic wait_read(input int rd0, input int bound);
    int n;
    n = 0;
    while (rd_cnt == rd0 && n < bound) begin
      tick();
      n++;
    end
    if (rd_cnt == rd0) chk("read_wait", 64'(rd_cnt), 64'(rd0 + 1));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    ticks(2);
    reset = 1'b1;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 64'({ifc.upd_ready, ifc.upd_done, err_timeout, ifc.read_en, ifc.write_en}), 64'd0);
    chk({tag, "_addr"}, 64'({ifc.read_addr, ifc.write_addr}), 64'd0);
    chk({tag, "_wdata"}, ifc.write_data, 64'd0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [PW-1:0] old_pkt;
    logic [FW-1:0] old_byt;
    logic [BW-1:0] ub;
    logic [PW-1:0] exp_pkt;
    logic [FW-1:0] exp_byt;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rd0, wr0, dn0, n;
    logic [WW-1:0] ew;
    int exp_ev[4];

    vecs[0] = '{10'd12, 24'd5,         40'd100,          16'd60,    24'd6,         40'd160};
    vecs[1] = '{10'd13, 24'hFFFFFF,    40'hFFFFFFFFFF,   16'd1500,  24'hFFFFFF,    40'hFFFFFFFFFF};
    vecs[2] = '{10'd14, 24'hFFFFFF,    40'd0,            16'd0,     24'hFFFFFF,    40'd0};
    vecs[3] = '{10'd15, 24'd0,         40'hFFFFFFFF9B,   16'd100,   24'd1,         40'hFFFFFFFFFF};
    vecs[4] = '{10'd16, 24'd7,         40'hFFFFFFFF9C,   16'd100,   24'd8,         40'hFFFFFFFFFF};
    vecs[5] = '{10'd17, 24'hFFFFFE,    40'd0,            16'hFFFF,  24'hFFFFFF,    40'd65535};

    ifc.upd_valid = 1'b0;
    ifc.upd_addr = '0;
    ifc.upd_bytes = '0;
    ifc.read_ready = 1'b1;
    ifc.write_ready = 1'b1;
    #2 reset = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 8; i++) begin
      ifc.upd_valid   = 1'($urandom);
      ifc.upd_addr    = AW'($urandom);
      ifc.upd_bytes   = BW'($urandom);
      ifc.read_ready  = 1'($urandom);
      ifc.write_ready = 1'($urandom);
      noise_rdn       = 1'($urandom);
      tick();
      chk_reset_outputs("reset_hold");
    end
    ifc.upd_valid = 1'b0;
    ifc.read_ready = 1'b1;
    ifc.write_ready = 1'b1;
    noise_rdn = 1'b0;
    reset = 1'b1;
    chk("ready_before_edge", 64'(ifc.upd_ready), 64'd0);
    tick();
    chk("ready_after_release", 64'(ifc.upd_ready), 64'd1);

    // Directed table: basic RMW, saturation and exact-boundary cases
    for (int i = 0; i < 6; i++) begin
      rd_lat = (i % 3) + 1;
      preload(int'(vecs[i].addr), {vecs[i].old_byt, vecs[i].old_pkt});
      rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
      send(vecs[i].addr, vecs[i].ub, acc);
      wait_write(wr0, 100);
      tick();
      ew = {vecs[i].exp_byt, vecs[i].exp_pkt};
      chk($sformatf("vec%0d_rd_count", i), 64'(rd_cnt - rd0), 64'd1);
      chk($sformatf("vec%0d_rd_addr", i), 64'(last_rd_addr), 64'(vecs[i].addr));
      chk($sformatf("vec%0d_wr_count", i), 64'(wr_cnt - wr0), 64'd1);
      chk($sformatf("vec%0d_done_count", i), 64'(done_cnt - dn0), 64'd1);
      chk($sformatf("vec%0d_wr_addr", i), 64'(last_wr_addr), 64'(vecs[i].addr));
      chk($sformatf("vec%0d_wr_data", i), last_wr_data, ew);
      chk($sformatf("vec%0d_lat_read", i), 64'(rd_cyc - acc), 64'd1);
      chk($sformatf("vec%0d_lat_write", i), 64'(wr_cyc - rd_cyc), 64'(rd_lat + 1));
      chk($sformatf("vec%0d_lat_ready", i), 64'(rdy_cyc - wr_cyc), 64'd1);
    end

    // Back-to-back with upd_valid held: strict read/write serialization
    rd_lat = 3;
    preload(1023, {40'd1000, 24'd10});
    preload(42, {40'd2000, 24'd20});
    ev_q.delete();
    wr0 = wr_cnt;
    ifc.upd_valid = 1'b1;
    ifc.upd_addr = 10'h3FF;
    ifc.upd_bytes = 16'd7;
    wait_accept(acc);
    ifc.upd_addr = 10'd42;
    ifc.upd_bytes = 16'd9;
    wait_accept(acc);
    ifc.upd_valid = 1'b0;
    n = 0;
    while (wr_cnt < wr0 + 2 && n < 200) begin tick(); n++; end
    tick();
    exp_ev = '{1023, 32'h10000 | 1023, 42, 32'h10000 | 42};
    chk("b2b_event_count", 64'(ev_q.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < ev_q.size()) chk($sformatf("b2b_event%0d", k), 64'(ev_q[k]), 64'(exp_ev[k]));
    chk("b2b_word_hi", mem[1023], {40'd1007, 24'd11});
    chk("b2b_word_42", mem[42], {40'd2009, 24'd21});

    // Back-pressure: read_ready low after reset, then write_ready low in WR_REQ
    ifc.read_ready = 1'b0;
    do_reset();
    preload(30, {40'd50, 24'd3});
    rd0 = rd_cnt; wr0 = wr_cnt;
    send(10'd30, 16'd10, acc);
    ticks(40);
    chk("bp_no_read", 64'(rd_cnt), 64'(rd0));
    chk("bp_no_timeout", 64'(err_timeout), 64'd0);
    ifc.write_ready = 1'b0;
    ifc.read_ready = 1'b1;
    wait_read(rd0, 20);
    ticks(rd_lat + 6);
    chk("bp_write_held", 64'(wr_cnt), 64'(wr0));
    ifc.write_ready = 1'b1;
    wait_write(wr0, 20);
    ticks(5);
    chk("bp_single_write", 64'(wr_cnt - wr0), 64'd1);
    chk("bp_write_delayed", 64'(wr_cyc - rd_cyc > rd_lat + 1), 64'd1);
    chk("bp_word", mem[30], {40'd60, 24'd4});

    // Read data in the same cycle the count reaches TIMEOUT: data wins
    rd_lat = 255;
    preload(31, {40'd1, 24'd1});
    wr0 = wr_cnt;
    send(10'd31, 16'd1, acc);
    wait_write(wr0, 700);
    tick();
    chk("edge_no_timeout", 64'(err_timeout), 64'd0);
    chk("edge_write_lat", 64'(wr_cyc - rd_cyc), 64'd256);
    chk("edge_word", mem[31], {40'd2, 24'd2});

    // Timeout: no read response ever arrives
    rd_lat = 2;
    suppress = 1'b1;
    preload(20, {40'd5, 24'd5});
    wr0 = wr_cnt;
    send(10'd20, 16'd5, acc);
    n = 0;
    while (!err_timeout && n < 600) begin tick(); n++; end
    chk("tmo_flag", 64'(err_timeout), 64'd1);
    tick();
    chk("tmo_latency", 64'(err_cyc - rd_cyc), 64'd255);
    chk("tmo_ready_next", 64'(ifc.upd_ready), 64'd1);
    chk("tmo_no_write", 64'(wr_cnt), 64'(wr0));
    noise_rdn = 1'b1;
    ticks(3);
    noise_rdn = 1'b0;
    ticks(2);
    chk("stray_no_write", 64'(wr_cnt), 64'(wr0));
    chk("stray_ready", 64'(ifc.upd_ready), 64'd1);
    suppress = 1'b0;
    preload(21, {40'd9, 24'd9});
    send(10'd21, 16'd1, acc);
    wait_write(wr0, 100);
    tick();
    chk("tmo_sticky", 64'(err_timeout), 64'd1);
    chk("after_tmo_word", mem[21], {40'd10, 24'd10});

    // Reset in the middle of an update drops it without a write
    rd_lat = 20;
    preload(33, {40'd0, 24'd0});
    rd0 = rd_cnt; wr0 = wr_cnt;
    send(10'd33, 16'd4, acc);
    wait_read(rd0, 20);
    ticks(3);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_outputs("reset_mid");
    tick();
    reset = 1'b1;
    ticks(30);
    chk("reset_mid_no_write", 64'(wr_cnt), 64'(wr0));
    chk("reset_mid_word", mem[33], 64'd0);

    // Randomized traffic against the model
    for (int a = 0; a < 8; a++) begin
      case (a % 4)
        0: preload(a, {32'($urandom), 32'($urandom)});
        1: preload(a, {40'($urandom), 24'hFFFFFF - 24'($urandom_range(0, 3))});
        2: preload(a, {40'hFFFFFF0000 | 40'($urandom_range(0, 65535)), 24'($urandom)});
        default: preload(a, {40'hFFFFFFFFFF, 24'hFFFFFF});
      endcase
    end
    wr0 = wr_cnt;
    for (int i = 0; i < 60; i++) begin
      rd_lat = $urandom_range(1, 6);
      ticks($urandom_range(0, 3));
      dn0 = wr_cnt;
      send(AW'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 16'hFFFF : BW'($urandom), acc);
      n = 0;
      while (wr_cnt == dn0 && n < 300) begin
        ifc.read_ready  = ($urandom_range(0, 3) != 0);
        ifc.write_ready = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      if (wr_cnt == dn0) chk("rand_write_wait", 64'(wr_cnt), 64'(dn0 + 1));
      ifc.read_ready = 1'b1;
      ifc.write_ready = 1'b1;
      tick();
    end
    chk("rand_write_count", 64'(wr_cnt - wr0), 64'd60);
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("rand_no_timeout", 64'(err_timeout), 64'd0);
    for (int a = 0; a < 8; a++) chk($sformatf("rand_mem%0d", a), mem[a], ref_mem[a]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
